lsu_mem_ctrl: RTL and testbench

Load/store unit sitting directly upstream of the team's 256-word synchronous data memory. The memory is word-wide, has no byte enables and returns registered read data one cycle after the address is applied. This block accepts RV32I load/store requests from the core and performs byte/halfword extraction with sign/zero extension. Sub-word stores are done as read-modify-write sequences. It returns one response per request over a valid/ready handshake.

---
 rtl/lsu_mem_ctrl_if.sv | 28 ++
 rtl/lsu_mem_ctrl.sv | 125 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: core request/response and data-memory signals of the load/store unit.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
   );
   modport mem (
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit for a word-wide synchronous memory; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
   parameter bit FAULT_ON_MISALIGN = 1'b1
) (
   input logic           clk,
   input logic           rst,
   lsu_mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ACCESS, DATA, WRITE, FAULT} state_t;
   state_t      r_state, w_state;
   logic        r_we, w_we, r_mem_we, w_mem_we, r_valid, w_valid, r_fault, w_fault;
   logic [2:0]  r_f3, w_f3;
   logic [1:0]  r_off, w_off, w_req_off;
   logic [31:0] r_mem_addr, w_mem_addr, r_mem_wdata, w_mem_wdata, r_rdata, w_rdata;
   logic        w_illegal, w_misal, w_bad;
   logic [4:0]  w_sh;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_mask, w_merged, w_load;
   assign w_illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                                 : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
   assign w_misal = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                    (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
   assign w_bad = w_illegal || (FAULT_ON_MISALIGN && w_misal);
   // Offset is forced to natural alignment; only matters when misalignment does not fault.
   assign w_req_off = bus.req_funct3[1:0] == 2'b10 ? 2'b00 :
                      bus.req_funct3[1:0] == 2'b01 ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
   assign w_sh = {r_off, 3'b000};
   assign w_byte = 8'(bus.mem_rdata >> w_sh);
   assign w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
   assign w_load = r_f3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
                   r_f3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
                   r_f3 == 3'b100 ? {24'd0, w_byte} :
                   r_f3 == 3'b101 ? {16'd0, w_half} : bus.mem_rdata;
   // mem_wdata still holds the request's store data until the merged word replaces it.
   assign w_mask = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
   assign w_merged = (bus.mem_rdata & ~w_mask) | ((r_mem_wdata << w_sh) & w_mask);
   assign bus.req_ready = r_state == IDLE;
   assign bus.resp_valid = r_valid;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_fault = r_fault;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_we = r_mem_we;
   assign bus.mem_wdata = r_mem_wdata;
   always_comb begin
      w_state = r_state;
      w_we = r_we;
      w_f3 = r_f3;
      w_off = r_off;
      w_mem_addr = r_mem_addr;
      w_mem_we = 1'b0;
      w_mem_wdata = r_mem_wdata;
      w_valid = 1'b0;
      w_fault = r_fault;
      w_rdata = r_rdata;
      case (r_state)
         IDLE: if (bus.req_valid) begin
            w_we = bus.req_we;
            w_f3 = bus.req_funct3;
            w_off = w_req_off;
            if (w_bad) w_state = FAULT;
            else begin
               w_mem_addr = {2'b00, bus.req_addr[31:2]};
               w_mem_we = bus.req_we && bus.req_funct3 == 3'b010;
               w_mem_wdata = bus.req_wdata;
               w_state = ACCESS;
            end
         end
         ACCESS: if (r_we && r_f3 == 3'b010) begin
            w_valid = 1'b1;
            w_fault = 1'b0;
            w_rdata = 32'd0;
            w_state = IDLE;
         end else w_state = DATA;
         DATA: if (!r_we) begin
            w_valid = 1'b1;
            w_fault = 1'b0;
            w_rdata = w_load;
            w_state = IDLE;
         end else begin
            w_mem_wdata = w_merged;
            w_mem_we = 1'b1;
            w_state = WRITE;
         end
         WRITE: begin
            w_valid = 1'b1;
            w_fault = 1'b0;
            w_rdata = 32'd0;
            w_state = IDLE;
         end
         FAULT: begin
            w_valid = 1'b1;
            w_fault = 1'b1;
            w_rdata = 32'd0;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_we <= 1'b0;
         r_f3 <= 3'd0;
         r_off <= 2'd0;
         r_mem_addr <= 32'd0;
         r_mem_we <= 1'b0;
         r_mem_wdata <= 32'd0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state;
         r_we <= w_we;
         r_f3 <= w_f3;
         r_off <= w_off;
         r_mem_addr <= w_mem_addr;
         r_mem_we <= w_mem_we;
         r_mem_wdata <= w_mem_wdata;
         r_valid <= w_valid;
         r_fault <= w_fault;
         r_rdata <= w_rdata;
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: drives two LSUs (fault-on-misalign and align-and-perform) in lockstep,
// each with its own memory model, and scoreboards their responses and latencies.
module tb_lsu_mem_ctrl;
   typedef struct {logic [31:0] rdata; logic fault; int lat;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic preload = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int wr0 = 0;
   int wr1 = 0;
   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   exp_t q0 [$];
   exp_t q1 [$];
   int acc0 [$];
   int acc1 [$];
   lsu_mem_ctrl_if bus0 ();
   lsu_mem_ctrl_if bus1 ();
   assign bus1.req_valid = bus0.req_valid;
   assign bus1.req_we = bus0.req_we;
   assign bus1.req_funct3 = bus0.req_funct3;
   assign bus1.req_addr = bus0.req_addr;
   assign bus1.req_wdata = bus0.req_wdata;
   lsu_mem_ctrl #(.FAULT_ON_MISALIGN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   lsu_mem_ctrl #(.FAULT_ON_MISALIGN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (preload) begin
         mem0[1] <= 32'h8081_82F3;
         mem0[2] <= 32'h0BAD_F00D;
         mem1[1] <= 32'h8081_82F3;
         mem1[2] <= 32'h0BAD_F00D;
      end else begin
         if (bus0.mem_we) begin
            mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
            wr0 <= wr0 + 1;
         end
         if (bus1.mem_we) begin
            mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
            wr1 <= wr1 + 1;
         end
      end
      bus0.mem_rdata <= mem0[bus0.mem_addr[7:0]];
      bus1.mem_rdata <= mem1[bus1.mem_addr[7:0]];
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e0;
      int a0;
      if (rst) acc0.delete();
      else begin
         if (bus0.resp_valid) begin
            if (q0.size() == 0 || acc0.size() == 0) chk("dut0 unexpected resp_valid", 32'd1, 32'd0);
            else begin
               e0 = q0.pop_front();
               a0 = acc0.pop_front();
               chk("dut0 rdata", bus0.resp_rdata, e0.rdata);
               chk("dut0 fault", {31'd0, bus0.resp_fault}, {31'd0, e0.fault});
               chk("dut0 latency", cyc - a0, e0.lat);
            end
         end
         if (bus0.req_valid && bus0.req_ready) acc0.push_back(cyc + 1);
      end
   end
   always @(negedge clk) begin
      exp_t e1;
      int a1;
      if (rst) acc1.delete();
      else begin
         if (bus1.resp_valid) begin
            if (q1.size() == 0 || acc1.size() == 0) chk("dut1 unexpected resp_valid", 32'd1, 32'd0);
            else begin
               e1 = q1.pop_front();
               a1 = acc1.pop_front();
               chk("dut1 rdata", bus1.resp_rdata, e1.rdata);
               chk("dut1 fault", {31'd0, bus1.resp_fault}, {31'd0, e1.fault});
               chk("dut1 latency", cyc - a1, e1.lat);
            end
         end
         if (bus1.req_valid && bus1.req_ready) acc1.push_back(cyc + 1);
      end
   end
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] r0, input logic f0, input int l0,
                        input logic [31:0] r1, input logic f1, input int l1,
                        input bit hold, input bit expect_resp);
      bit ok = 1'b0;
      if (expect_resp) begin
         q0.push_back('{r0, f0, l0});
         q1.push_back('{r1, f1, l1});
      end
      bus0.req_we = we;
      bus0.req_funct3 = f3;
      bus0.req_addr = addr;
      bus0.req_wdata = wd;
      bus0.req_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = bus0.req_ready && bus1.req_ready;
      end
      chk("accept within bound", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #2;
      if (!hold) bus0.req_valid = 1'b0;
   endtask
   task automatic same(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] r, input logic f, input int l);
      issue(we, f3, addr, wd, r, f, l, r, f, l, 1'b0, 1'b1);
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   initial begin
      int w0s, w1s;
      bus0.req_valid = 1'b0;
      bus0.req_we = 1'b0;
      bus0.req_funct3 = 3'd0;
      bus0.req_addr = 32'd0;
      bus0.req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      preload = 1'b0;
      chk("reset req_ready", {31'd0, bus0.req_ready}, 32'd1);
      chk("reset resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
      chk("reset resp_fault", {31'd0, bus0.resp_fault}, 32'd0);
      chk("reset resp_rdata", bus0.resp_rdata, 32'd0);
      chk("reset mem_addr", bus0.mem_addr, 32'd0);
      chk("reset mem_we", {31'd0, bus0.mem_we}, 32'd0);
      chk("reset mem_wdata", bus0.mem_wdata, 32'd0);
      chk("reset dut1 req_ready", {31'd0, bus1.req_ready}, 32'd1);
      same(1'b0, 3'b010, 32'h4, 32'd0, 32'h8081_82F3, 1'b0, 2);
      idle(4);
      same(1'b0, 3'b000, 32'h7, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
      idle(4);
      same(1'b0, 3'b100, 32'h7, 32'd0, 32'h0000_0080, 1'b0, 2);
      idle(4);
      same(1'b0, 3'b001, 32'h6, 32'd0, 32'hFFFF_8081, 1'b0, 2);
      idle(4);
      same(1'b0, 3'b101, 32'h4, 32'd0, 32'h0000_82F3, 1'b0, 2);
      idle(4);
      same(1'b1, 3'b000, 32'h5, 32'h1234_56AA, 32'd0, 1'b0, 3);
      idle(5);
      chk("SB merge mem0[1]", mem0[1], 32'h8081_AAF3);
      chk("SB merge mem1[1]", mem1[1], 32'h8081_AAF3);
      same(1'b1, 3'b001, 32'h6, 32'h0000_1234, 32'd0, 1'b0, 3);
      idle(5);
      chk("SH merge mem0[1]", mem0[1], 32'h1234_AAF3);
      chk("SH merge mem1[1]", mem1[1], 32'h1234_AAF3);
      w0s = wr0;
      issue(1'b0, 3'b010, 32'h6, 32'd0, 32'd0, 1'b1, 1, 32'h1234_AAF3, 1'b0, 2, 1'b0, 1'b1);
      idle(4);
      same(1'b0, 3'b011, 32'h4, 32'd0, 32'd0, 1'b1, 1);
      idle(4);
      same(1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
      idle(4);
      chk("no write on faults", wr0, w0s);
      issue(1'b1, 3'b001, 32'h5, 32'h0000_5555, 32'd0, 1'b1, 1, 32'd0, 1'b0, 3, 1'b0, 1'b1);
      idle(5);
      chk("misaligned SH fault mem0[1]", mem0[1], 32'h1234_AAF3);
      chk("misaligned SH aligned mem1[1]", mem1[1], 32'h1234_5555);
      issue(1'b0, 3'b010, 32'h404, 32'd0, 32'h1234_AAF3, 1'b0, 2, 32'h1234_5555, 1'b0, 2, 1'b0, 1'b1);
      chk("wrap mem_addr", bus0.mem_addr, 32'h101);
      idle(4);
      issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 32'd0, 1'b0, 1, 1'b1, 1'b1);
      same(1'b0, 3'b010, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
      idle(4);
      chk("SW mem0[2]", mem0[2], 32'hDEAD_BEEF);
      w0s = wr0;
      w1s = wr1;
      issue(1'b1, 3'b000, 32'h9, 32'h0000_0011, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      chk("post-reset req_ready", {31'd0, bus0.req_ready}, 32'd1);
      chk("post-reset mem_we", {31'd0, bus0.mem_we}, 32'd0);
      idle(5);
      chk("reset abort no write dut0", wr0, w0s);
      chk("reset abort no write dut1", wr1, w1s);
      chk("reset abort mem0[2]", mem0[2], 32'hDEAD_BEEF);
      same(1'b0, 3'b000, 32'h9, 32'd0, 32'hFFFF_FFBE, 1'b0, 2);
      idle(4);
      same(1'b0, 3'b101, 32'hA, 32'd0, 32'h0000_DEAD, 1'b0, 2);
      idle(4);
      chk("dut0 responses outstanding", q0.size(), 32'd0);
      chk("dut1 responses outstanding", q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
